// File: rtl/matrix_input_loader.sv
// Streams A (M x K) and B (K x N) matrices from an AXI-stream slave into local memories for a compute engine.
// Define MATRIX_INPUT_LOADER_DBUF_EN to double-buffer B so the next B load can overlap compute.
module matrix_input_loader #(
    parameter int unsigned INW  = 12,
    parameter int unsigned M    = 7,
    parameter int unsigned N    = 9,
    parameter int unsigned MAXK = 8,
    localparam int unsigned K_BITS      = $clog2(MAXK + 1),
    localparam int unsigned A_ADDR_BITS = $clog2(M * MAXK),
    localparam int unsigned B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic        [INW-1:0]         AXIS_TDATA,
    input  logic                          AXIS_TVALID,
    output logic                          AXIS_TREADY,
    input  logic        [K_BITS:0]        AXIS_TUSER,
    output logic                          matrices_loaded,
    input  logic                          compute_finished,
    output logic        [K_BITS-1:0]      K,
    input  logic        [A_ADDR_BITS-1:0] A_read_addr,
    output logic signed [INW-1:0]         A_data,
    input  logic        [B_ADDR_BITS-1:0] B_read_addr,
    output logic signed [INW-1:0]         B_data
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FULL} state_t;

    state_t                 state_q, state_d;
    logic [K_BITS-1:0]      k_q, k_d, k_in, k_cur;
    logic [A_ADDR_BITS-1:0] a_waddr_q, a_waddr_d, a_last;
    logic [B_ADDR_BITS-1:0] b_waddr_q, b_waddr_d, b_last;
    logic                   rdy_q, accept, new_a, k_ok, a_we, b_we, load_done;

    assign new_a  = AXIS_TUSER[0];
    assign k_in   = AXIS_TUSER[K_BITS:1];
    assign k_ok   = (k_in != '0) && (32'(k_in) <= MAXK);
    assign accept = AXIS_TVALID && AXIS_TREADY;

    // The first beat of an A load carries K; every other beat uses the stored K.
    assign k_cur  = (state_q == IDLE && new_a) ? k_in : k_q;
    assign a_last = A_ADDR_BITS'(M * 32'(k_cur) - 1);
    assign b_last = B_ADDR_BITS'(32'(k_cur) * N - 1);
    assign K      = k_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_waddr_d = a_waddr_q;
        b_waddr_d = b_waddr_q;
        a_we      = 1'b0;
        b_we      = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (new_a) begin
                        if (k_ok) begin
                            k_d  = k_in;
                            a_we = 1'b1;
                        end
                    end else begin
                        b_we = 1'b1;
                    end
                end
            end
            LOAD_A: a_we = accept;
            LOAD_B: b_we = accept;
            FULL:   if (compute_finished) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Address counters sit at zero between loads, so the first beat lands at address 0.
        if (a_we) begin
            if (a_waddr_q == a_last) begin
                a_waddr_d = '0;
                state_d   = LOAD_B;
            end else begin
                a_waddr_d = a_waddr_q + A_ADDR_BITS'(1);
                state_d   = LOAD_A;
            end
        end
        if (b_we) begin
            if (b_waddr_q == b_last) begin
                b_waddr_d = '0;
                load_done = 1'b1;
`ifdef MATRIX_INPUT_LOADER_DBUF_EN
                state_d   = IDLE;
`else
                state_d   = FULL;
`endif
            end else begin
                b_waddr_d = b_waddr_q + B_ADDR_BITS'(1);
                state_d   = LOAD_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_waddr_q <= '0;
            b_waddr_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_waddr_q <= a_waddr_d;
            b_waddr_q <= b_waddr_d;
            rdy_q     <= 1'b1;
        end
    end

    logic signed [INW-1:0] a_mem [M*MAXK];

    always_ff @(posedge clk) begin
        if (a_we) a_mem[a_waddr_q] <= AXIS_TDATA;
        A_data <= a_mem[A_read_addr];
    end

`ifdef MATRIX_INPUT_LOADER_DBUF_EN
    logic [1:0] full_q, full_d;
    logic       wp_q, rp_q, clr;

    assign matrices_loaded = full_q[rp_q];
    assign clr             = compute_finished && full_q[rp_q];
    // A new A (and K) may only land once no loaded B bank still depends on the old one.
    assign AXIS_TREADY     = rdy_q && !full_q[wp_q]
                             && !(state_q == IDLE && new_a && full_q != 2'b00);

    always_comb begin
        full_d = full_q;
        if (clr)       full_d[rp_q] = 1'b0;
        if (load_done) full_d[wp_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            wp_q   <= wp_q ^ load_done;
            rp_q   <= rp_q ^ clr;
        end
    end

    logic signed [INW-1:0] b_mem [2][MAXK*N];

    always_ff @(posedge clk) begin
        if (b_we) b_mem[wp_q][b_waddr_q] <= AXIS_TDATA;
        B_data <= b_mem[rp_q][B_read_addr];
    end
`else
    assign matrices_loaded = (state_q == FULL);
    assign AXIS_TREADY     = rdy_q && (state_q != FULL);

    logic signed [INW-1:0] b_mem [MAXK*N];

    always_ff @(posedge clk) begin
        if (b_we) b_mem[b_waddr_q] <= AXIS_TDATA;
        B_data <= b_mem[B_read_addr];
    end
`endif

endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed self-checking bench for matrix_input_loader (default parameters).
module tb_matrix_input_loader;

    logic               clk = 1'b0;
    logic               reset;
    logic        [11:0] AXIS_TDATA;
    logic               AXIS_TVALID;
    logic               AXIS_TREADY;
    logic        [4:0]  AXIS_TUSER;
    logic               matrices_loaded;
    logic               compute_finished;
    logic        [3:0]  K;
    logic        [5:0]  A_read_addr;
    logic signed [11:0] A_data;
    logic        [6:0]  B_read_addr;
    logic signed [11:0] B_data;

    int checks   = 0;
    int failures = 0;
    int accepted_cnt = 0;

    matrix_input_loader dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TREADY      (AXIS_TREADY),
        .AXIS_TUSER       (AXIS_TUSER),
        .matrices_loaded  (matrices_loaded),
        .compute_finished (compute_finished),
        .K                (K),
        .A_read_addr      (A_read_addr),
        .A_data           (A_data),
        .B_read_addr      (B_read_addr),
        .B_data           (B_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (AXIS_TVALID && AXIS_TREADY) accepted_cnt <= accepted_cnt + 1;

    task automatic send_beat(input int data, input logic [4:0] tuser);
        int n;
        AXIS_TDATA  = 12'(data);
        AXIS_TUSER  = tuser;
        AXIS_TVALID = 1'b1;
        #1;
        n = 0;
        while (!AXIS_TREADY && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!AXIS_TREADY) begin
            checks++; failures++;
            $display("FAIL send_beat_timeout data=%0d tready=%0b required 1", data, AXIS_TREADY);
        end else begin
            @(posedge clk); #1;
        end
        AXIS_TVALID = 1'b0;
    endtask

    task automatic read_a(input int addr, output logic signed [11:0] v);
        A_read_addr = 6'(addr);
        @(posedge clk); #1;
        v = A_data;
    endtask

    task automatic read_b(input int addr, output logic signed [11:0] v);
        B_read_addr = 7'(addr);
        @(posedge clk); #1;
        v = B_data;
    endtask

    task automatic pulse_compute();
        compute_finished = 1'b1;
        @(posedge clk); #1;
        compute_finished = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL reset_tready got=%0b exp=0", AXIS_TREADY); end
        checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL reset_loaded got=%0b exp=0", matrices_loaded); end
        checks++; if (K !== 4'd0) begin failures++; $display("FAIL reset_k got=%0d exp=0", K); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (AXIS_TREADY !== 1'b1) begin failures++; $display("FAIL post_reset_tready got=%0b exp=1", AXIS_TREADY); end
    endtask

    task automatic test_load_new_a();
        logic signed [11:0] v;
        for (int i = 1; i <= 14; i++) send_beat(i, (i == 1) ? 5'd5 : 5'd0);
        for (int j = 1; j <= 18; j++) begin
            if (j == 18) begin
                checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL load_early_loaded got=%0b exp=0", matrices_loaded); end
            end
            send_beat(100 + j, 5'd0);
        end
        checks++; if (matrices_loaded !== 1'b1) begin failures++; $display("FAIL load_loaded got=%0b exp=1", matrices_loaded); end
        checks++; if (K !== 4'd2) begin failures++; $display("FAIL load_k got=%0d exp=2", K); end
`ifndef MATRIX_INPUT_LOADER_DBUF_EN
        checks++; if (AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL full_tready got=%0b exp=0", AXIS_TREADY); end
`endif
        read_a(13, v);
        checks++; if (v !== 12'sd14) begin failures++; $display("FAIL load_a13 got=%0d exp=14", v); end
        read_b(0, v);
        checks++; if (v !== 12'sd101) begin failures++; $display("FAIL load_b0 got=%0d exp=101", v); end
    endtask

    task automatic test_reuse_a();
        logic signed [11:0] v;
        pulse_compute();
        checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL reuse_cleared got=%0b exp=0", matrices_loaded); end
        checks++; if (AXIS_TREADY !== 1'b1) begin failures++; $display("FAIL reuse_tready got=%0b exp=1", AXIS_TREADY); end
        for (int j = 1; j <= 18; j++) send_beat(200 + j, (j == 1) ? 5'd10 : 5'd0);
        checks++; if (matrices_loaded !== 1'b1) begin failures++; $display("FAIL reuse_loaded got=%0b exp=1", matrices_loaded); end
        checks++; if (K !== 4'd2) begin failures++; $display("FAIL reuse_k got=%0d exp=2", K); end
        read_a(0, v);
        checks++; if (v !== 12'sd1) begin failures++; $display("FAIL reuse_a0 got=%0d exp=1", v); end
        read_b(17, v);
        checks++; if (v !== 12'sd218) begin failures++; $display("FAIL reuse_b17 got=%0d exp=218", v); end
        read_b(0, v);
        checks++; if (v !== 12'sd201) begin failures++; $display("FAIL reuse_b0 got=%0d exp=201", v); end
    endtask

    task automatic test_tvalid_gaps();
        logic signed [11:0] v;
        logic signed [11:0] exp_b9;
        int start;
        pulse_compute();
        start = accepted_cnt;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL gaps_early_loaded got=%0b exp=0", matrices_loaded); end
            end
            send_beat(31 + i, (i == 0) ? 5'd3 : 5'd0);
            @(posedge clk); #1;
        end
        checks++; if (accepted_cnt - start !== 16) begin failures++; $display("FAIL gaps_beats got=%0d exp=16", accepted_cnt - start); end
        checks++; if (matrices_loaded !== 1'b1) begin failures++; $display("FAIL gaps_loaded got=%0b exp=1", matrices_loaded); end
        read_a(6, v);
        checks++; if (v !== 12'sd37) begin failures++; $display("FAIL gaps_a6 got=%0d exp=37", v); end
        read_a(7, v);
        checks++; if (v !== 12'sd8) begin failures++; $display("FAIL gaps_a7_untouched got=%0d exp=8", v); end
        read_b(0, v);
        checks++; if (v !== 12'sd38) begin failures++; $display("FAIL gaps_b0 got=%0d exp=38", v); end
        read_b(8, v);
        checks++; if (v !== 12'sd46) begin failures++; $display("FAIL gaps_b8 got=%0d exp=46", v); end
`ifdef MATRIX_INPUT_LOADER_DBUF_EN
        exp_b9 = 12'sd110;
`else
        exp_b9 = 12'sd210;
`endif
        read_b(9, v);
        checks++; if (v !== exp_b9) begin failures++; $display("FAIL gaps_b9_untouched got=%0d exp=%0d", v, exp_b9); end
    endtask

    task automatic test_bad_k();
        logic signed [11:0] v;
        pulse_compute();
        send_beat(999, 5'd19);
        checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL badk9_loaded got=%0b exp=0", matrices_loaded); end
        checks++; if (AXIS_TREADY !== 1'b1) begin failures++; $display("FAIL badk9_tready got=%0b exp=1", AXIS_TREADY); end
        checks++; if (K !== 4'd1) begin failures++; $display("FAIL badk9_k got=%0d exp=1", K); end
        send_beat(888, 5'd1);
        checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL badk0_loaded got=%0b exp=0", matrices_loaded); end
        read_a(0, v);
        checks++; if (v !== 12'sd31) begin failures++; $display("FAIL badk_a0 got=%0d exp=31", v); end
    endtask

    task automatic test_reset_mid_load();
        logic signed [11:0] v;
        int start;
        for (int i = 0; i < 5; i++) send_beat(51 + i, (i == 0) ? 5'd3 : 5'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL midrst_loaded got=%0b exp=0", matrices_loaded); end
        checks++; if (K !== 4'd0) begin failures++; $display("FAIL midrst_k got=%0d exp=0", K); end
        reset = 1'b0;
        @(posedge clk); #1;
        start = accepted_cnt;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (matrices_loaded !== 1'b0) begin failures++; $display("FAIL midrst_early_loaded got=%0b exp=0", matrices_loaded); end
            end
            send_beat(61 + i, (i == 0) ? 5'd3 : 5'd0);
        end
        checks++; if (accepted_cnt - start !== 16) begin failures++; $display("FAIL midrst_beats got=%0d exp=16", accepted_cnt - start); end
        checks++; if (matrices_loaded !== 1'b1) begin failures++; $display("FAIL midrst_loaded_after got=%0b exp=1", matrices_loaded); end
        checks++; if (K !== 4'd1) begin failures++; $display("FAIL midrst_k_after got=%0d exp=1", K); end
        read_a(0, v);
        checks++; if (v !== 12'sd61) begin failures++; $display("FAIL midrst_a0 got=%0d exp=61", v); end
        read_a(6, v);
        checks++; if (v !== 12'sd67) begin failures++; $display("FAIL midrst_a6 got=%0d exp=67", v); end
        read_b(0, v);
        checks++; if (v !== 12'sd68) begin failures++; $display("FAIL midrst_b0 got=%0d exp=68", v); end
        read_b(8, v);
        checks++; if (v !== 12'sd76) begin failures++; $display("FAIL midrst_b8 got=%0d exp=76", v); end
    endtask

`ifdef MATRIX_INPUT_LOADER_DBUF_EN
    task automatic test_back_to_back();
        logic signed [11:0] v;
        pulse_compute();
        for (int j = 0; j < 9; j++) send_beat(301 + j, 5'd0);
        for (int j = 0; j < 9; j++) send_beat(401 + j, 5'd0);
        checks++; if (AXIS_TREADY !== 1'b0) begin failures++; $display("FAIL dbuf_tready_full got=%0b exp=0", AXIS_TREADY); end
        checks++; if (matrices_loaded !== 1'b1) begin failures++; $display("FAIL dbuf_loaded got=%0b exp=1", matrices_loaded); end
        read_b(0, v);
        checks++; if (v !== 12'sd301) begin failures++; $display("FAIL dbuf_first_bank got=%0d exp=301", v); end
        pulse_compute();
        checks++; if (AXIS_TREADY !== 1'b1) begin failures++; $display("FAIL dbuf_tready_freed got=%0b exp=1", AXIS_TREADY); end
        checks++; if (matrices_loaded !== 1'b1) begin failures++; $display("FAIL dbuf_second_loaded got=%0b exp=1", matrices_loaded); end
        read_b(0, v);
        checks++; if (v !== 12'sd401) begin failures++; $display("FAIL dbuf_second_bank got=%0d exp=401", v); end
    endtask
`endif

    initial begin
        reset            = 1'b1;
        AXIS_TDATA       = '0;
        AXIS_TVALID      = 1'b0;
        AXIS_TUSER       = '0;
        compute_finished = 1'b0;
        A_read_addr      = '0;
        B_read_addr      = '0;
        test_reset();
        test_load_new_a();
        test_reuse_a();
        test_tvalid_gaps();
        test_bad_k();
        test_reset_mid_load();
`ifdef MATRIX_INPUT_LOADER_DBUF_EN
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_input_loader.md
MATRIX_INPUT_LOADER -- requirements
Module: matrix_input_loader

Interface
REQ-001 SHALL have parameter INW, default 12: signed element width in bits.
REQ-002 SHALL have parameter M, default 7: rows of A.
REQ-003 SHALL have parameter N, default 9: columns of B.
REQ-004 SHALL have parameter MAXK, default 8: maximum shared dimension K.
REQ-005 SHALL derive localparams K_BITS=$clog2(MAXK+1), A_ADDR_BITS=$clog2(M*MAXK), B_ADDR_BITS=$clog2(MAXK*N).
REQ-006 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have ports AXIS_TDATA input INW, AXIS_TVALID input 1, AXIS_TREADY output 1: stream slave.
REQ-009 SHALL have port AXIS_TUSER, input, K_BITS+1: bit0 new_A; bits [K_BITS:1] K.
REQ-010 SHALL have ports matrices_loaded output 1 and compute_finished input 1: compute handshake.
REQ-011 SHALL have port K, output, K_BITS: K of the matrices being presented.
REQ-012 SHALL have ports A_read_addr input A_ADDR_BITS and A_data output signed INW.
REQ-013 SHALL have ports B_read_addr input B_ADDR_BITS and B_data output signed INW.

Function
REQ-014 SHALL accept a beat only when AXIS_TVALID and AXIS_TREADY are both 1 in the same cycle.
REQ-015 SHALL sample AXIS_TUSER only on the first beat of a load. new_A=1: M*K A beats, then K*N B beats. new_A=0: K*N B beats only, reusing stored A and stored K.
REQ-016 SHALL latch K only when new_A=1. The K field SHALL be ignored when new_A=0.
REQ-017 SHALL write beat i of A to A address i and beat j of B to B address j (row-major), starting at 0.
REQ-018 SHALL discard a first beat with new_A=1 and K=0 or K>MAXK (accepted, not written) and remain in IDLE.
REQ-019 SHALL implement the load FSM:
  - IDLE -> LOAD_A on a first beat with new_A=1 (that beat is written to A[0]).
  - IDLE -> LOAD_B on a first beat with new_A=0 (that beat is written to B[0]).
  - LOAD_A -> LOAD_B after beat M*K-1.
  - LOAD_B -> FULL after beat K*N-1.
REQ-020 SHALL give A_data/B_data one-cycle read latency: the data for an address presented in cycle t is valid in cycle t+1. Reads SHALL operate regardless of FSM state.
REQ-021 SHALL hold the output K constant while matrices_loaded=1.
REQ-022 SHALL ignore compute_finished while matrices_loaded=0.
REQ-023 SHALL hold AXIS_TREADY=0 in FULL (single-buffer mode). compute_finished=1 in FULL SHALL cause FULL -> IDLE; matrices_loaded=0 and AXIS_TREADY=1 on the next cycle.
REQ-024 SHALL assert matrices_loaded=1 starting the cycle after the final B beat is accepted.
REQ-025 SHALL support a TVALID low mid-load: the FSM holds, no write occurs, and the address does not advance.

Reset
REQ-026 reset=1 SHALL force IDLE, clear write addresses, set AXIS_TREADY=0, matrices_loaded=0, K=0, and clear all bank flags, on the next edge.
REQ-027 SHALL assert AXIS_TREADY=1 the first cycle after reset deasserts.
REQ-028 reset mid-load SHALL abandon the partial load. Memory contents SHALL not be cleared.
REQ-029 SHALL treat a load with new_A=0 before any valid A as legal; A contents are then unspecified.

Configuration
REQ-030 SHALL support macro MATRIX_INPUT_LOADER_DBUF_EN. Undefined: a single B memory, behaviour as in REQ-023.
REQ-031 With MATRIX_INPUT_LOADER_DBUF_EN defined, B SHALL be double-buffered:
  - Two B banks with full flags f[0..1], write pointer wp, and read pointer rp.
  - Load-B completion SHALL set f[wp] and toggle wp.
  - matrices_loaded SHALL equal f[rp]; B reads SHALL come from bank rp.
  - compute_finished with matrices_loaded=1 SHALL clear f[rp] and toggle rp.
  - AXIS_TREADY SHALL be 0 while f[wp]=1.
  - A first beat with new_A=1 SHALL be stalled (TREADY=0) until f[0]=f[1]=0.
  - The compute clear and the load set SHALL both take effect when they fall in the same cycle.

Verification
REQ-032 Reset, then load new_A=1, K=2: 14 A beats (values 1..14) then 18 B beats (101..118). Required: matrices_loaded=1 the cycle after the last beat; K=2; A_read_addr=13 gives A_data=14 one cycle later; B_read_addr=0 gives 101.
REQ-033 Pulse compute_finished, then load new_A=0 with TUSER K=5 and 18 B beats (201..218). Required: K stays 2; A_data at address 0 is 1; B_data at address 17 is 218.
REQ-034 TVALID toggled every other cycle during a K=1 load. Required: exactly 7+9 writes, and matrices_loaded only after the 16th accepted beat.
REQ-035 First beat new_A=1, K=9 (MAXK=8). Required: beat consumed, FSM stays IDLE, matrices_loaded=0.
REQ-036 reset asserted after 5 A beats, then a full K=1 load. Required: correct data, matrices_loaded=1 only after that load.
REQ-037 DBUF_EN: two back-to-back B loads with no compute_finished. Required: TREADY=0 after the second load; compute_finished then switches B_data to the second bank's data and TREADY=1 the next cycle.
